// File: rtl/floo_vc_credit_scheduler.sv
// Round-robin output-link scheduler with per-VC credit counters and wormhole locks.
// Optional same-cycle credit bypass: define FLOO_VC_SCHED_CREDIT_BYPASS_EN.
module floo_vc_credit_scheduler #(
    parameter int unsigned NumReq       = 4,
    parameter int unsigned NumVC        = 4,
    parameter int unsigned NumVCWidth   = NumVC > 1 ? $clog2(NumVC) : 1,
    parameter int unsigned VCDepth      = 2,
    parameter int unsigned VCDepthWidth = $clog2(VCDepth + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumReq-1:0]                      req_valid_i,
    input  logic [NumReq-1:0][NumVCWidth-1:0]      req_vc_i,
    input  logic [NumReq-1:0]                      req_last_i,
    output logic [NumReq-1:0]                      gnt_o,
    output logic                                   out_valid_o,
    output logic [NumVCWidth-1:0]                  out_vc_o,
    input  logic                                   credit_v_i,
    input  logic [NumVCWidth-1:0]                  credit_id_i,
    output logic [NumVC-1:0][VCDepthWidth-1:0]     credit_o,
    output logic                                   err_o
);
    localparam int unsigned ReqWidth = NumReq > 1 ? $clog2(NumReq) : 1;
    localparam logic [VCDepthWidth-1:0] CreditMax = VCDepthWidth'(VCDepth);

    logic [NumVC-1:0][VCDepthWidth-1:0] credit_q, credit_d;
    logic [NumVC-1:0]                   lock_q, lock_d;
    logic [NumVC-1:0][ReqWidth-1:0]     owner_q, owner_d;
    logic [ReqWidth-1:0]                rr_q, rr_d;
    logic                               err_q, err_d;

    logic [NumVC-1:0]      vc_avail;
    logic [NumVC-1:0]      credit_ret;
    logic [NumVC-1:0]      credit_take;
    logic [NumReq-1:0]     eligible;
    logic                  found;
    logic                  grant;
    logic [ReqWidth-1:0]   win_idx;
    logic [NumVCWidth-1:0] win_vc;
    logic                  win_last;

    for (genvar gi = 0; gi < NumVC; gi++) begin : g_vc
`ifdef FLOO_VC_SCHED_CREDIT_BYPASS_EN
        assign vc_avail[gi] = (credit_q[gi] != '0) ||
                              (credit_v_i && (credit_id_i == NumVCWidth'(gi)));
`else
        assign vc_avail[gi] = (credit_q[gi] != '0);
`endif
        assign credit_ret[gi]  = credit_v_i && (credit_id_i == NumVCWidth'(gi));
        assign credit_take[gi] = grant && (win_vc == NumVCWidth'(gi));
    end

    // A locked VC only accepts flits from the requester that opened the packet.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
        assign eligible[gi] = req_valid_i[gi] && vc_avail[req_vc_i[gi]] &&
                              (!lock_q[req_vc_i[gi]] ||
                               (owner_q[req_vc_i[gi]] == ReqWidth'(gi)));
    end

    always_comb begin
        int unsigned idx;
        idx     = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win_idx = ReqWidth'(idx);
            end
        end
    end

    assign grant       = found && !rst_i;
    assign win_vc      = req_vc_i[win_idx];
    assign win_last    = req_last_i[win_idx];
    assign gnt_o       = grant ? (NumReq'(1) << win_idx) : '0;
    assign out_valid_o = grant;
    assign out_vc_o    = grant ? win_vc : '0;
    assign credit_o    = credit_q;
    assign err_o       = err_q;

    always_comb begin
        credit_d = credit_q;
        lock_d   = lock_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        err_d    = err_q;
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (credit_ret[v] && !credit_take[v]) begin
                if (credit_q[v] == CreditMax) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + VCDepthWidth'(1);
                end
            end else if (credit_take[v] && !credit_ret[v]) begin
                credit_d[v] = credit_q[v] - VCDepthWidth'(1);
            end
        end
        // The pointer only moves at packet boundaries so a wormhole is never split.
        if (grant) begin
            if (win_last) begin
                lock_d[win_vc] = 1'b0;
                if (win_idx == ReqWidth'(NumReq - 1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = win_idx + ReqWidth'(1);
                end
            end else begin
                lock_d[win_vc]  = 1'b1;
                owner_d[win_vc] = win_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_q <= {NumVC{CreditMax}};
            lock_q   <= '0;
            owner_q  <= '0;
            rr_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_floo_vc_credit_scheduler.sv
// Directed bench for floo_vc_credit_scheduler: reset, round-robin, wormhole lock,
// credit timing (both bypass builds), overflow and mid-packet reset.
module tb_floo_vc_credit_scheduler;
    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [3:0]      req_valid_i;
    logic [3:0][1:0] req_vc_i;
    logic [3:0]      req_last_i;
    logic [3:0]      gnt_o;
    logic            out_valid_o;
    logic [1:0]      out_vc_o;
    logic            credit_v_i;
    logic [1:0]      credit_id_i;
    logic [3:0][1:0] credit_o;
    logic            err_o;

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    floo_vc_credit_scheduler #(
        .NumReq (4),
        .NumVC  (4),
        .VCDepth(2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_valid_i(req_valid_i),
        .req_vc_i   (req_vc_i),
        .req_last_i (req_last_i),
        .gnt_o      (gnt_o),
        .out_valid_o(out_valid_o),
        .out_vc_o   (out_vc_o),
        .credit_v_i (credit_v_i),
        .credit_id_i(credit_id_i),
        .credit_o   (credit_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; checks follow 1 time unit later.
    task automatic cyc(input logic rst, input logic [3:0] v, input logic [7:0] vc,
                       input logic [3:0] last, input logic cv, input logic [1:0] cid);
        @(negedge clk_i);
        rst_i       = rst;
        req_valid_i = v;
        req_vc_i    = vc;
        req_last_i  = last;
        credit_v_i  = cv;
        credit_id_i = cid;
        #1;
        step++;
        $display("step %0d rst=%b valid=%b vc=%h last=%b cr=%b/%0d -> gnt=%b vc=%0d credit=%h err=%b",
                 step, rst, v, vc, last, cv, cid, gnt_o, out_vc_o, credit_o, err_o);
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = '0; req_vc_i = '0; req_last_i = '0;
        credit_v_i = 1'b0; credit_id_i = '0;

        // Reset holds outputs low even with a valid request
        cyc(1, 4'b0001, 8'h00, 4'b1111, 0, 0);
        check("rst_gnt", gnt_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_vc", out_vc_o, 0);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 0, 0);
        check("init_credit", credit_o, 32'hAA);
        check("init_gnt", gnt_o, 0);
        check("init_err", err_o, 0);

        // Requesters 0 and 2 on VC1, single-flit packets
        cyc(0, 4'b0101, 8'h11, 4'b1111, 0, 0);
        check("rr_first_gnt", gnt_o, 4'b0001);
        check("rr_first_vc", out_vc_o, 1);
        cyc(0, 4'b0101, 8'h11, 4'b1111, 0, 0);
        check("rr_second_gnt", gnt_o, 4'b0100);
        check("vc1_credit_1", credit_o[1], 1);
        cyc(0, 4'b0101, 8'h11, 4'b1111, 0, 0);
        check("no_credit_gnt", gnt_o, 0);
        check("vc1_credit_0", credit_o[1], 0);
        cyc(0, 4'b0101, 8'h11, 4'b1111, 0, 0);
        check("no_credit_valid", out_valid_o, 0);

        // Credit return onto an empty VC1
        cyc(0, 4'b0001, 8'h01, 4'b1111, 1, 1);
`ifdef FLOO_VC_SCHED_CREDIT_BYPASS_EN
        check("bypass_gnt", gnt_o, 4'b0001);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 0, 0);
        check("bypass_credit", credit_o[1], 0);
`else
        check("nobypass_gnt", gnt_o, 0);
        cyc(0, 4'b0001, 8'h01, 4'b1111, 0, 0);
        check("nobypass_credit", credit_o[1], 1);
        check("nobypass_late_gnt", gnt_o, 4'b0001);
`endif
        cyc(0, 4'b0000, 8'h00, 4'b0000, 1, 1);
        check("vc1_after_grant", credit_o[1], 0);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 1, 1);
        check("vc1_refill_1", credit_o[1], 1);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 0, 0);
        check("vc1_refill_full", credit_o, 32'hAA);

        // Wormhole: req1 sends 3 flits on VC0 while req3 waits on VC0
        cyc(0, 4'b1010, 8'h00, 4'b1000, 0, 0);
        check("worm_head_gnt", gnt_o, 4'b0010);
        check("worm_head_vc", out_vc_o, 0);
        cyc(0, 4'b1010, 8'h00, 4'b1000, 1, 0);
        check("worm_body_gnt", gnt_o, 4'b0010);
        check("worm_body_credit", credit_o[0], 1);
        cyc(0, 4'b1010, 8'h00, 4'b1010, 1, 0);
        check("worm_tail_gnt", gnt_o, 4'b0010);
        check("worm_net_credit", credit_o[0], 1);
        cyc(0, 4'b1000, 8'h00, 4'b1000, 0, 0);
        check("worm_waiter_gnt", gnt_o, 4'b1000);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 0, 0);
        check("worm_credit", credit_o, 32'hA8);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 0, 0);
        check("vc0_refill_full", credit_o, 32'hAA);

        // Overflowing return on a full VC2
        cyc(0, 4'b0000, 8'h00, 4'b0000, 1, 2);
        check("ovf_err_before", err_o, 0);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 0, 0);
        check("ovf_credit_sat", credit_o, 32'hAA);
        check("ovf_err_set", err_o, 1);
        cyc(0, 4'b0000, 8'h00, 4'b0000, 0, 0);
        check("ovf_err_sticky", err_o, 1);

        // Reset in the middle of a VC3 packet owned by requester 2
        cyc(0, 4'b0100, 8'h30, 4'b0000, 0, 0);
        check("mid_head_gnt", gnt_o, 4'b0100);
        check("mid_head_vc", out_vc_o, 3);
        cyc(0, 4'b0001, 8'h03, 4'b0001, 0, 0);
        check("mid_locked_gnt", gnt_o, 0);
        check("mid_vc3_credit", credit_o[3], 1);
        cyc(1, 4'b0001, 8'h03, 4'b0001, 0, 0);
        check("mid_rst_gnt", gnt_o, 0);
        check("mid_rst_valid", out_valid_o, 0);
        cyc(0, 4'b0001, 8'h03, 4'b0001, 0, 0);
        check("post_rst_gnt", gnt_o, 4'b0001);
        check("post_rst_vc", out_vc_o, 3);
        check("post_rst_credit", credit_o, 32'hAA);
        check("post_rst_err", err_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
